// File: rtl/sys_probe_pkg.sv
// Shared encodings and defaults for the LED probe display and its users.
package sys_probe_pkg;

  localparam int unsigned DEFAULT_DIVISOR = 50_000_000;

  localparam logic [1:0] MODE_LIVE   = 2'b00;
  localparam logic [1:0] MODE_FREEZE = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;

  typedef enum logic [1:0] {
    ST_LIVE   = 2'd0,
    ST_FREEZE = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

endpackage

// File: rtl/sys_tick_gen.sv
// Free-running divider: tick_c_o is high during the last cycle of each DIVISOR-cycle period.
module sys_tick_gen
  import sys_probe_pkg::*;
#(
  parameter int unsigned DIVISOR = DEFAULT_DIVISOR
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_c_o
);

  localparam int unsigned CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // With DIVISOR=1 the counter is pinned at 0, so the tick stays high.
  assign tick_c_o = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (tick_c_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sys_probe_display.sv
// LED debug display: picks one of N_CH probe channels (live, frozen or auto-scanned)
// and refreshes the LEDs once per divider period.
module sys_probe_display
  import sys_probe_pkg::*;
#(
  parameter int unsigned DIVISOR = DEFAULT_DIVISOR,
  parameter int unsigned N_CH    = 8,
  parameter int unsigned CH_W    = 27,
  parameter int unsigned SEL_W   = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   SYS_reset,
  input  logic [N_CH*CH_W-1:0]   SYS_probe_data,
  input  logic [SEL_W-1:0]       SYS_output_sel,
  input  logic [1:0]             SYS_mode,
  output logic [CH_W-1:0]        SYS_leds,
  output logic [SEL_W-1:0]       SYS_ch_idx,
  output logic                   SYS_tick
);

  logic             tick_c;
  state_e           st_q, st_d;
  logic [CH_W-1:0]  leds_q, leds_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             tick_q;
  logic [SEL_W-1:0] scan_nxt_c;
  logic [CH_W-1:0]  live_data_c, scan_data_c;

  sys_tick_gen #(.DIVISOR(DIVISOR)) u_tick_gen (
    .clk      (clk),
    .rst_n    (SYS_reset),
    .tick_c_o (tick_c)
  );

  // Mode is re-sampled every cycle; the reserved encoding falls back to LIVE.
  always_comb begin
    st_d = ST_LIVE;
    case (SYS_mode)
      MODE_FREEZE: st_d = ST_FREEZE;
      MODE_SCAN:   st_d = ST_SCAN;
      default:     st_d = ST_LIVE;
    endcase
  end

  // Out-of-range selects match no channel, so they read as zero.
  always_comb begin
    scan_nxt_c  = (idx_q >= SEL_W'(N_CH - 1)) ? '0 : idx_q + SEL_W'(1);
    live_data_c = '0;
    scan_data_c = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (SYS_output_sel == SEL_W'(k)) live_data_c = SYS_probe_data[k*CH_W +: CH_W];
      if (scan_nxt_c == SEL_W'(k))     scan_data_c = SYS_probe_data[k*CH_W +: CH_W];
    end
  end

  always_comb begin
    leds_d = leds_q;
    idx_d  = idx_q;
    if (tick_c) begin
      case (st_q)
        ST_LIVE: begin
          leds_d = live_data_c;
          idx_d  = SYS_output_sel;
        end
        ST_SCAN: begin
          leds_d = scan_data_c;
          idx_d  = scan_nxt_c;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      st_q   <= ST_LIVE;
      leds_q <= '0;
      idx_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      leds_q <= leds_d;
      idx_q  <= idx_d;
      tick_q <= tick_c;
    end
  end

  assign SYS_leds   = leds_q;
  assign SYS_ch_idx = idx_q;
  assign SYS_tick   = tick_q;

endmodule
